parity_frame_serializer: RTL and testbench

- Upstream feeder for the serial Mealy parity checker.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on ser_x, which drives the checker's x input.
- Provides frame markers and a registered running even-parity value, so the bench can cross-check the checker's parity output bit by bit.

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_frame_serializer_if.sv | 24 ++
 rtl/parity_shift_reg.sv | 30 +++
 rtl/parity_frame_serializer.sv | 130 +++++++++++++
 tb/tb_parity_frame_serializer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared encodings for the parity frame serializer and its downstream checker.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_e;

    // Bit-counter width for a frame of w data bits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/parity_frame_serializer_if.sv
// Upstream word handshake plus serial frame outputs of the parity frame serializer.
interface parity_frame_serializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_x;
    logic              ser_valid;
    logic              ser_first;
    logic              ser_last;
    logic              run_parity;
    logic              busy;

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_x, ser_valid, ser_first, ser_last, run_parity, busy
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_x, ser_valid, ser_first, ser_last, run_parity, busy
    );
endinterface

// File: rtl/parity_shift_reg.sv
// Loadable shift register; head_c is the bit that will be at the output end after this cycle's update.
module parity_shift_reg #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              head_c
);
    logic [DATA_W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = LSB_FIRST ? {1'b0, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], 1'b0};
        end
    end

    assign head_c = LSB_FIRST ? sr_d[0] : sr_d[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end
endmodule

// File: rtl/parity_frame_serializer.sv
// Serializes handshaked words onto ser_x with frame markers and running even parity.
// Build option PARITY_APPEND_EN appends one even-parity bit to every frame.
module parity_frame_serializer
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic                      clk,
    input logic                      rst_n,
    parity_frame_serializer_if.slave bus
);
    localparam int unsigned      CNT_W   = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_x_q, ser_x_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic             run_parity_q, run_parity_d;
    logic             busy_q, busy_d;
    logic             load, shift, head_c, frame_end_c, ready_c, xfer_c;

    parity_shift_reg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .load_data (bus.in_data),
        .head_c    (head_c)
    );

    // The cycle carrying ser_last can also accept the next word.
`ifdef PARITY_APPEND_EN
    assign frame_end_c = (state_q == ST_PAR);
`else
    assign frame_end_c = (state_q == ST_SHIFT) && (cnt_q == CNT_MAX);
`endif
    assign ready_c = rst_n && ((state_q == ST_IDLE) || frame_end_c);
    assign xfer_c  = bus.in_valid && ready_c;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load         = 1'b0;
        shift        = 1'b0;
        ser_x_d      = 1'b0;
        ser_valid_d  = 1'b0;
        ser_first_d  = 1'b0;
        ser_last_d   = 1'b0;
        run_parity_d = run_parity_q;
        busy_d       = 1'b0;
        if (xfer_c) begin
            load         = 1'b1;
            state_d      = ST_SHIFT;
            cnt_d        = '0;
            ser_x_d      = head_c;
            ser_valid_d  = 1'b1;
            ser_first_d  = 1'b1;
            run_parity_d = head_c;
            busy_d       = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != CNT_MAX) begin
                        shift        = 1'b1;
                        cnt_d        = cnt_q + CNT_W'(1);
                        ser_x_d      = head_c;
                        ser_valid_d  = 1'b1;
                        run_parity_d = run_parity_q ^ head_c;
                        busy_d       = 1'b1;
`ifndef PARITY_APPEND_EN
                        ser_last_d   = (cnt_q + CNT_W'(1)) == CNT_MAX;
`endif
                    end else begin
                        cnt_d = '0;
`ifdef PARITY_APPEND_EN
                        // run_parity_q already covers every data bit; appending it balances the frame.
                        state_d      = ST_PAR;
                        ser_x_d      = run_parity_q;
                        ser_valid_d  = 1'b1;
                        ser_last_d   = 1'b1;
                        run_parity_d = 1'b0;
                        busy_d       = 1'b1;
`else
                        state_d      = ST_IDLE;
`endif
                    end
                end
                ST_PAR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ser_x_q      <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_first_q  <= 1'b0;
            ser_last_q   <= 1'b0;
            run_parity_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ser_x_q      <= ser_x_d;
            ser_valid_q  <= ser_valid_d;
            ser_first_q  <= ser_first_d;
            ser_last_q   <= ser_last_d;
            run_parity_q <= run_parity_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.ser_x      = ser_x_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_first  = ser_first_q;
    assign bus.ser_last   = ser_last_q;
    assign bus.run_parity = run_parity_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_parity_frame_serializer.sv
// Scoreboard bench for parity_frame_serializer: one LSB-first and one MSB-first instance.
module tb_parity_frame_serializer;
    localparam int unsigned W = 8;
`ifdef PARITY_APPEND_EN
    localparam int unsigned FLEN = W + 1;
`else
    localparam int unsigned FLEN = W;
`endif

    typedef struct packed {
        logic x;
        logic first;
        logic last;
        logic par;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         msb;
        logic       exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parity_frame_serializer_if #(.DATA_W(W)) bus_l ();
    parity_frame_serializer_if #(.DATA_W(W)) bus_m ();

    parity_frame_serializer #(.DATA_W(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bus_l));
    parity_frame_serializer #(.DATA_W(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(bus_m));

    exp_t q_l[$];
    exp_t q_m[$];
    int   nvec = 0;
    int   nerr = 0;
    logic last_x[2];
    logic last_par[2];
    int   run_len[2];
    int   streak[2];
    int   max_streak[2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input bit msb);
        return msb ? bus_m.in_ready : bus_l.in_ready;
    endfunction

    function automatic logic sval(input bit msb);
        return msb ? bus_m.ser_valid : bus_l.ser_valid;
    endfunction

    function automatic int qsize(input bit msb);
        return msb ? q_m.size() : q_l.size();
    endfunction

    task automatic drive(input bit msb, input logic [7:0] d, input logic v);
        if (msb) begin bus_m.in_data = d; bus_m.in_valid = v; end
        else     begin bus_l.in_data = d; bus_l.in_valid = v; end
    endtask

    // Independent model of one frame: bit order, markers and running parity.
    task automatic push_frame(input bit msb, input logic [7:0] d);
        exp_t e;
        logic p = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            e.x     = msb ? d[int'(W) - 1 - i] : d[i];
            p       = p ^ e.x;
            e.first = (i == 0);
`ifdef PARITY_APPEND_EN
            e.last  = 1'b0;
`else
            e.last  = (i == int'(W) - 1);
`endif
            e.par   = p;
            if (msb) q_m.push_back(e); else q_l.push_back(e);
        end
`ifdef PARITY_APPEND_EN
        e.x = p; e.first = 1'b0; e.last = 1'b1; e.par = 1'b0;
        if (msb) q_m.push_back(e); else q_l.push_back(e);
`endif
    endtask

    task automatic mon(input bit msb, input logic x, input logic v, input logic f,
                       input logic l, input logic p, input logic b, input logic r);
        exp_t  e;
        int    idx = msb ? 1 : 0;
        string s   = msb ? "msb" : "lsb";
        if (v) begin
            streak[idx]++;
            if (streak[idx] > max_streak[idx]) max_streak[idx] = streak[idx];
            if (qsize(msb) == 0) begin
                nvec++; nerr++;
                $display("FAIL %s_unexpected_valid: got ser_valid 1 want 0 at %0t", s, $time);
                return;
            end
            e = msb ? q_m.pop_front() : q_l.pop_front();
            cmp({s, "_x"},     32'(x), 32'(e.x));
            cmp({s, "_first"}, 32'(f), 32'(e.first));
            cmp({s, "_last"},  32'(l), 32'(e.last));
            cmp({s, "_par"},   32'(p), 32'(e.par));
            cmp({s, "_busy"},  32'(b), 32'd1);
            cmp({s, "_ready"}, 32'(r), 32'(e.last));
            if (f) run_len[idx] = 1; else run_len[idx]++;
            if (l) begin
                cmp({s, "_len"}, 32'(run_len[idx]), 32'(FLEN));
                last_x[idx]   = x;
                last_par[idx] = p;
            end
        end else begin
            streak[idx] = 0;
            cmp({s, "_idle_x"},     32'(x), 32'd0);
            cmp({s, "_idle_first"}, 32'(f), 32'd0);
            cmp({s, "_idle_last"},  32'(l), 32'd0);
            cmp({s, "_idle_busy"},  32'(b), 32'd0);
            cmp({s, "_idle_ready"}, 32'(r), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0, bus_l.ser_x, bus_l.ser_valid, bus_l.ser_first, bus_l.ser_last,
                bus_l.run_parity, bus_l.busy, bus_l.in_ready);
            mon(1'b1, bus_m.ser_x, bus_m.ser_valid, bus_m.ser_first, bus_m.ser_last,
                bus_m.run_parity, bus_m.busy, bus_m.in_ready);
        end
    end

    // Offer a word, push its expected frame when it is accepted, and check first-bit latency.
    task automatic send(input bit msb, input logic [7:0] d, input bit keep);
        int n = 0;
        @(posedge clk); #1;
        drive(msb, d, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(msb) && n < 200);
        if (!rdy(msb)) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: got in_ready 0 want 1 after %0d cycles", n);
            drive(msb, d, 1'b0);
            return;
        end
        push_frame(msb, d);
        @(posedge clk); #1;
        if (!keep) drive(msb, d, 1'b0);
        @(negedge clk);
        cmp("latency_valid", 32'(sval(msb)), 32'd1);
        cmp("latency_first", 32'(msb ? bus_m.ser_first : bus_l.ser_first), 32'd1);
    endtask

    task automatic wait_idle(input bit msb);
        int n = 0;
        while (n < 200 && (sval(msb) || qsize(msb) != 0)) begin
            @(negedge clk);
            n++;
        end
        if (sval(msb) || qsize(msb) != 0) begin
            nvec++; nerr++;
            $display("FAIL idle_timeout: got %0d pending bits want 0", qsize(msb));
        end
    endtask

    task automatic check_all_zero(input string name);
        cmp({name, "_x"},     32'(bus_l.ser_x),      32'd0);
        cmp({name, "_valid"}, 32'(bus_l.ser_valid),  32'd0);
        cmp({name, "_first"}, 32'(bus_l.ser_first),  32'd0);
        cmp({name, "_last"},  32'(bus_l.ser_last),   32'd0);
        cmp({name, "_par"},   32'(bus_l.run_parity), 32'd0);
        cmp({name, "_busy"},  32'(bus_l.busy),       32'd0);
        cmp({name, "_ready"}, 32'(bus_l.in_ready),   32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int idx;
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1};
        vecs[2] = '{8'h07, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'h01, 1'b0, 1'b1};
        vecs[9] = '{8'hFE, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            run_len[i] = 0; streak[i] = 0; max_streak[i] = 0;
        end
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);

        #3;
        check_all_zero("reset");
        #9 rst_n = 1'b1;

        foreach (vecs[i]) begin
            idx = vecs[i].msb ? 1 : 0;
            last_x[idx]   = 1'bx;
            last_par[idx] = 1'bx;
            send(vecs[i].msb, vecs[i].data, 1'b0);
            wait_idle(vecs[i].msb);
`ifdef PARITY_APPEND_EN
            cmp("tbl_par_bit",   32'(last_x[idx]),   32'(vecs[i].exp_par));
            cmp("tbl_final_par", 32'(last_par[idx]), 32'd0);
            cmp("tbl_idle_hold", 32'(vecs[i].msb ? bus_m.run_parity : bus_l.run_parity), 32'd0);
`else
            cmp("tbl_final_par", 32'(last_par[idx]), 32'(vecs[i].exp_par));
            cmp("tbl_idle_hold", 32'(vecs[i].msb ? bus_m.run_parity : bus_l.run_parity),
                32'(vecs[i].exp_par));
`endif
        end

        // Back-to-back frames with in_valid held high throughout.
        max_streak[0] = 0;
        send(1'b0, 8'hFF, 1'b1);
        send(1'b0, 8'h00, 1'b0);
        wait_idle(1'b0);
        cmp("b2b_streak", 32'(max_streak[0]), 32'(2 * FLEN));

        // Asynchronous reset in the middle of a frame.
        send(1'b0, 8'hA5, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        q_l.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        last_par[0] = 1'bx;
        send(1'b0, 8'h3C, 1'b0);
        wait_idle(1'b0);
        cmp("post_reset_par", 32'(last_par[0]), 32'd0);

        // Long idle with no offered words.
        repeat (20) begin
            @(negedge clk);
            cmp("bp_valid", 32'(bus_l.ser_valid), 32'd0);
            cmp("bp_x",     32'(bus_l.ser_x),     32'd0);
            cmp("bp_ready", 32'(bus_l.in_ready),  32'd1);
        end

        cmp("q_l_empty", 32'(q_l.size()), 32'd0);
        cmp("q_m_empty", 32'(q_m.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
